// File: rtl/leg_solver_pkg.sv
// Shared types and widths for the leg solver: y = floor(sqrt(r^2 - x^2)).
package leg_solver_pkg;
   localparam int unsigned W      = 8;
   localparam int unsigned RAD_W  = 16;
   localparam int unsigned REM_W  = W + 2;
   localparam int unsigned ITER_W = 3;

   typedef enum logic [1:0] {IDLE, SUB, ROOT, DONE} state_t;
endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root step: brings in two radicand bits, yields one root bit.
module isqrt_step
   import leg_solver_pkg::*;
(
   input  logic [REM_W-1:0] rem,
   input  logic [W-1:0]     root,
   input  logic [1:0]       rad_bits,
   output logic [REM_W-1:0] rem_nxt,
   output logic [W-1:0]     root_nxt
);
   logic [REM_W-1:0] rem_sh;
   logic [REM_W-1:0] trial;

   always_comb begin
      rem_sh = (rem << 2) | REM_W'(rad_bits);
      trial  = {root, 2'b01};
      if (rem_sh >= trial) begin
         rem_nxt  = rem_sh - trial;
         root_nxt = (root << 1) | W'(1);
      end else begin
         rem_nxt  = rem_sh;
         root_nxt = root << 1;
      end
   end
endmodule

// File: rtl/leg_solver.sv
// Sequential leg solver: square-and-subtract, then 8 shift/subtract root steps.
module leg_solver
   import leg_solver_pkg::*;
#(
   parameter int unsigned W = 8
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ena,
   input  logic         start,
   input  logic [W-1:0] r_in,
   input  logic [W-1:0] x_in,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] y_out,
   output logic         err
);
   state_t            state;
   logic [W-1:0]      r_q;
   logic [W-1:0]      x_q;
   logic [RAD_W-1:0]  rad;
   logic              neg;
   logic [REM_W-1:0]  rem;
   logic [W-1:0]      root;
   logic [ITER_W-1:0] iter;

   logic [RAD_W-1:0]  sq_r;
   logic [RAD_W-1:0]  sq_x;
   logic [RAD_W:0]    diff;
   logic [1:0]        rad_bits;
   logic [REM_W-1:0]  rem_nxt;
   logic [W-1:0]      root_nxt;

   always_comb begin
      sq_r     = RAD_W'(r_q) * RAD_W'(r_q);
      sq_x     = RAD_W'(x_q) * RAD_W'(x_q);
      diff     = {1'b0, sq_r} - {1'b0, sq_x};
      rad_bits = rad[{iter, 1'b0} +: 2];
   end

   isqrt_step u_step (
      .rem      (rem),
      .root     (root),
      .rad_bits (rad_bits),
      .rem_nxt  (rem_nxt),
      .root_nxt (root_nxt)
   );

   // Result registers load on the final ROOT edge so done is valid one edge earlier
   // than a separate DONE-state load would allow; DONE then only retires the pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         r_q   <= '0;
         x_q   <= '0;
         rad   <= '0;
         neg   <= 1'b0;
         rem   <= '0;
         root  <= '0;
         iter  <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         y_out <= '0;
         err   <= 1'b0;
      end else if (ena) begin
         case (state)
            IDLE: begin
               if (start) begin
                  r_q   <= r_in;
                  x_q   <= x_in;
                  busy  <= 1'b1;
                  state <= SUB;
               end
            end
            SUB: begin
               neg   <= diff[RAD_W];
               rad   <= diff[RAD_W] ? '0 : diff[RAD_W-1:0];
               rem   <= '0;
               root  <= '0;
               iter  <= '1;
               state <= ROOT;
            end
            ROOT: begin
               rem  <= rem_nxt;
               root <= root_nxt;
               iter <= iter - 1'b1;
               if (iter == '0) begin
                  done  <= 1'b1;
                  y_out <= neg ? '0 : root_nxt;
                  err   <= neg;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
